// File: rtl/ram_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller: in-order command FIFO, on-chip memory,
// fixed-latency read return and optional periodic refresh stalls.
module ram_bram_responder #(
  parameter int MEM_ADDR_BITS    = 10,
  parameter int FIFO_DEPTH       = 4,
  parameter int READ_LATENCY     = 3,
  parameter int REFRESH_INTERVAL = 0,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] addr,
  input  logic        rw,
  input  logic [31:0] data_in,
  input  logic        in_valid,
  output logic        busy,
  output logic [31:0] data_out,
  output logic        out_valid
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int PL  = READ_LATENCY - 1;
  localparam int RIW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int RCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic {RUN, REFRESH} state_t;

  state_t                   state, state_nxt;
  logic [RIW-1:0]           ref_cnt;
  logic [RCW-1:0]           ref_len;

  logic                     fifo_rw   [FIFO_DEPTH];
  logic [MEM_ADDR_BITS-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]              fifo_data [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count, count_nxt;

  logic [31:0]              mem [2**MEM_ADDR_BITS];
  logic [PL-1:0]            pipe_valid;
  logic [31:0]              pipe_data [PL];

  logic                     push, pop;
  logic                     head_rw;
  logic [MEM_ADDR_BITS-1:0] head_addr;
  logic [31:0]              head_data;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^addr[22:MEM_ADDR_BITS];

  assign push      = in_valid && !busy;
  assign pop       = (count != '0) && (state == RUN);
  assign head_rw   = fifo_rw[rd_ptr];
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // RUN lasts REFRESH_INTERVAL cycles, then REFRESH holds off pops for REFRESH_CYCLES.
  always_comb begin
    state_nxt = state;
    if (REFRESH_INTERVAL != 0) begin
      if (state == RUN && ref_cnt == RIW'(REFRESH_INTERVAL - 1))
        state_nxt = REFRESH;
      else if (state == REFRESH && ref_len == RCW'(REFRESH_CYCLES - 1))
        state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      ref_cnt    <= '0;
      ref_len    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy       <= 1'b0;
      pipe_valid <= '0;
      for (int i = 0; i < PL; i++) pipe_data[i] <= '0;
    end else begin
      state   <= state_nxt;
      ref_cnt <= (state == RUN && state_nxt == RUN) ? ref_cnt + 1'b1 : '0;
      ref_len <= (state == REFRESH) ? ref_len + 1'b1 : '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      busy  <= (count_nxt == CW'(FIFO_DEPTH)) || (state_nxt == REFRESH);
      // Read data keeps moving even during refresh so in-flight returns are never delayed.
      pipe_valid[0] <= pop && !head_rw;
      pipe_data[0]  <= mem[head_addr];
      for (int i = 1; i < PL; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  // Storage arrays carry no reset so they map onto block RAM / distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[wr_ptr]   <= rw;
      fifo_addr[wr_ptr] <= addr[MEM_ADDR_BITS-1:0];
      fifo_data[wr_ptr] <= data_in;
    end
    if (pop && head_rw) mem[head_addr] <= head_data;
  end

  assign out_valid = pipe_valid[PL-1];
  assign data_out  = pipe_data[PL-1];

endmodule

// File: tb/tb_ram_bram_responder.sv
// Scoreboard bench for ram_bram_responder: one instance without refresh (exact latency
// checked) and one with REFRESH_INTERVAL=16 / REFRESH_CYCLES=4.
module tb_ram_bram_responder;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] addr0, addr1;
  logic        rw0, rw1;
  logic [31:0] din0, din1;
  logic        iv0, iv1;
  logic        busy0, busy1;
  logic [31:0] dout0, dout1;
  logic        ov0, ov1;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  exp_t        q0[$];
  logic [31:0] q1[$];
  logic [31:0] m0 [1024];
  logic [31:0] m1 [1024];
  bit          w1 [32];

  ram_bram_responder #(.READ_LATENCY(LAT)) dut0 (
    .clk(clk), .rst(rst), .addr(addr0), .rw(rw0), .data_in(din0), .in_valid(iv0),
    .busy(busy0), .data_out(dout0), .out_valid(ov0)
  );

  ram_bram_responder #(.READ_LATENCY(LAT), .REFRESH_INTERVAL(16), .REFRESH_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .addr(addr1), .rw(rw1), .data_in(din1), .in_valid(iv1),
    .busy(busy1), .data_out(dout1), .out_valid(ov1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Returns from the refresh-free instance must match both data and exact arrival cycle.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst && ov0) begin
      checks++;
      if (q0.size() == 0) begin
        fails++;
        $display("[TB] FAIL rd0_unexpected: out_valid=1 data=%h, required no return", dout0);
      end else begin
        e = q0.pop_front();
        if (dout0 !== e.data || cyc != e.due) begin
          fails++;
          $display("[TB] FAIL rd0_return: data=%h cycle=%0d, required data=%h cycle=%0d",
                   dout0, cyc, e.data, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [31:0] e;
    if (rst && ov1) begin
      checks++;
      if (q1.size() == 0) begin
        fails++;
        $display("[TB] FAIL rd1_unexpected: out_valid=1 data=%h, required no return", dout1);
      end else begin
        e = q1.pop_front();
        if (dout1 !== e) begin
          fails++;
          $display("[TB] FAIL rd1_return: data=%h, required %h", dout1, e);
        end
      end
    end
  end

  task automatic send0(input logic w, input logic [22:0] a, input logic [31:0] d);
    @(negedge clk);
    addr0 = a; rw0 = w; din0 = d; iv0 = 1'b1;
    if (!busy0) begin
      if (w) m0[a[9:0]] = d;
      else   q0.push_back('{data: m0[a[9:0]], due: cyc + LAT});
    end
  endtask

  task automatic idle0();
    @(negedge clk);
    iv0 = 1'b0;
  endtask

  task automatic send1(input logic w, input logic [22:0] a, input logic [31:0] d);
    bit done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      addr1 = a; rw1 = w; din1 = d; iv1 = 1'b1;
      if (!busy1) begin
        done = 1;
        if (w) m1[a[9:0]] = d;
        else   q1.push_back(m1[a[9:0]]);
      end
    end
    checks++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL send1_accept: accepted=0, required 1");
    end
  endtask

  task automatic idle1();
    @(negedge clk);
    iv1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    iv0 = 0; rw0 = 0; addr0 = '0; din0 = '0;
    iv1 = 0; rw1 = 0; addr1 = '0; din1 = '0;
    #12;
    checks += 5;
    if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy0: %b, required 0", busy0); end
    if (ov0 !== 1'b0)   begin fails++; $display("[TB] FAIL reset_ov0: %b, required 0", ov0); end
    if (dout0 !== 32'h0) begin fails++; $display("[TB] FAIL reset_dout0: %h, required 0", dout0); end
    if (busy1 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy1: %b, required 0", busy1); end
    if (ov1 !== 1'b0)   begin fails++; $display("[TB] FAIL reset_ov1: %b, required 0", ov1); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    send0(1'b1, 23'h000005, 32'hDEADBEEF);
    send0(1'b0, 23'h000005, 32'h0);
    idle0();
    for (int i = 0; i < 30 && q0.size() != 0; i++) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin fails++; $display("[TB] FAIL write_read_drain: pending=%0d, required 0", q0.size()); end
  endtask

  task automatic test_alias();
    send0(1'b1, 23'h000403, 32'hA5A5A5A5);
    send0(1'b0, 23'h000003, 32'h0);
    idle0();
    for (int i = 0; i < 30 && q0.size() != 0; i++) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin fails++; $display("[TB] FAIL alias_drain: pending=%0d, required 0", q0.size()); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) send0(1'b1, 23'(n), 32'h100 + 32'(n));
    idle0();
    repeat (3) @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      send0(1'b0, 23'(n), 32'h0);
      checks++;
      if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_busy: busy=%b at read %0d, required 0", busy0, n); end
    end
    idle0();
    for (int i = 0; i < 30 && q0.size() != 0; i++) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin fails++; $display("[TB] FAIL b2b_drain: pending=%0d, required 0", q0.size()); end
  endtask

  task automatic test_refresh();
    int  run   = 0;
    int  runs  = 0;
    bit  armed = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      addr1 = 23'(i & 31); rw1 = 1'b1; din1 = $urandom; iv1 = 1'b1;
      if (!busy1) begin
        m1[i & 31] = din1;
        w1[i & 31] = 1;
        if (armed && run > 0) begin
          checks++;
          runs++;
          if (run != 4) begin fails++; $display("[TB] FAIL refresh_stall_len: %0d cycles, required 4", run); end
        end
        armed = 1;
        run   = 0;
      end else if (armed) begin
        run++;
      end
    end
    idle1();
    checks++;
    if (runs < 2) begin fails++; $display("[TB] FAIL refresh_seen: %0d stalls, required at least 2", runs); end
    for (int a = 0; a < 32; a++) if (w1[a]) send1(1'b0, 23'(a), 32'h0);
    idle1();
    for (int i = 0; i < 60 && q1.size() != 0; i++) @(negedge clk);
    checks++;
    if (q1.size() != 0) begin fails++; $display("[TB] FAIL refresh_drain: pending=%0d, required 0", q1.size()); end
  endtask

  task automatic test_busy_drop();
    bit found = 0;
    send1(1'b1, 23'h000007, 32'h22222222);
    idle1();
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (busy1) begin
        found = 1;
        addr1 = 23'h000007; rw1 = 1'b1; din1 = 32'h11111111; iv1 = 1'b1;
      end
    end
    checks++;
    if (!found) begin fails++; $display("[TB] FAIL busy_drop_wait: busy never seen, required 1"); end
    idle1();
    send1(1'b0, 23'h000007, 32'h0);
    idle1();
    for (int i = 0; i < 60 && q1.size() != 0; i++) @(negedge clk);
    checks++;
    if (q1.size() != 0) begin fails++; $display("[TB] FAIL busy_drop_drain: pending=%0d, required 0", q1.size()); end
  endtask

  task automatic test_reset_in_flight();
    int seen = 0;
    send0(1'b0, 23'h000001, 32'h0);
    send0(1'b0, 23'h000002, 32'h0);
    send0(1'b0, 23'h000003, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    iv0 = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    checks += 3;
    if (ov0 !== 1'b0)    begin fails++; $display("[TB] FAIL rst_async_ov: %b, required 0", ov0); end
    if (busy0 !== 1'b0)  begin fails++; $display("[TB] FAIL rst_async_busy: %b, required 0", busy0); end
    if (dout0 !== 32'h0) begin fails++; $display("[TB] FAIL rst_async_dout: %h, required 0", dout0); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov0) seen++;
    end
    checks++;
    if (seen != 0) begin fails++; $display("[TB] FAIL rst_discard: %0d returns, required 0", seen); end
    send0(1'b0, 23'h000002, 32'h0);
    idle0();
    for (int i = 0; i < 30 && q0.size() != 0; i++) @(negedge clk);
    checks++;
    if (q0.size() != 0) begin fails++; $display("[TB] FAIL rst_fresh_drain: pending=%0d, required 0", q0.size()); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_refresh();
    test_busy_drop();
    test_reset_in_flight();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
